// File: rtl/pe_mac_lanes_pkg.sv
// Shared definitions for the multi-lane MAC processing element.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: FSM state enum, DRAIN_CYCLES, default accumulator width, and
// satAdd, the clamp-to-range adder used when PE_SAT_EN is defined.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } peState_t;

  localparam int DRAIN_CYCLES = 2;
  localparam int DEF_ACC_W    = 40;

  // Operands arrive sign-extended to 64 bits from an accW-bit value (accW <= 63).
  // The 65-bit sum cannot overflow, so the clamp compares against exact bounds.
  function automatic logic signed [63:0] satAdd(input logic signed [63:0] a,
                                                input logic signed [63:0] b,
                                                input int unsigned accW);
    logic signed [64:0] s;
    logic signed [64:0] maxV;
    logic signed [64:0] minV;
    s    = {a[63], a} + {b[63], b};
    maxV = (65'sd1 <<< (accW - 1)) - 65'sd1;
    minV = -(65'sd1 <<< (accW - 1));
    if (s > maxV) begin
      return maxV[63:0];
    end else if (s < minV) begin
      return minV[63:0];
    end
    return s[63:0];
  endfunction

endpackage

// File: rtl/pe_mac_lanes_if.sv
// Bus bundle between an array cell and its PE: store writes, run control,
// upstream partial sum and the valid/ready result handshake.
// Backpressure: adderOut/outValid are held by the slave until outReady.
// Modports: slave = the PE, master = whoever drives the PE.
interface pe_mac_lanes_if
  import pe_pkg::*;
#(
  parameter int W     = 16,
  parameter int A     = 7,
  parameter int LANES = 2,
  parameter int ACC_W = DEF_ACC_W
) ();

  logic                  kernelWrite;
  logic [A-1:0]          kernelWrAddr;
  logic [LANES*W-1:0]    kernelIn;
  logic                  neuronWrite;
  logic [A-1:0]          neuronWrAddr;
  logic [LANES*W-1:0]    neuronIn;
  logic                  start;
  logic [A-1:0]          baseK;
  logic [A-1:0]          baseN;
  logic [A-1:0]          strideN;
  logic [A-1:0]          len;
  logic [ACC_W-1:0]      adderIn;
  logic                  busy;
  logic                  outValid;
  logic                  outReady;
  logic [ACC_W-1:0]      adderOut;

  modport slave (
    input  kernelWrite, kernelWrAddr, kernelIn,
    input  neuronWrite, neuronWrAddr, neuronIn,
    input  start, baseK, baseN, strideN, len, adderIn, outReady,
    output busy, outValid, adderOut
  );

  modport master (
    output kernelWrite, kernelWrAddr, kernelIn,
    output neuronWrite, neuronWrAddr, neuronIn,
    output start, baseK, baseN, strideN, len, adderIn, outReady,
    input  busy, outValid, adderOut
  );

endinterface

// File: rtl/pe_lane_store.sv
// Local store: 2^A words of DW bits, one write port, one synchronous read port.
// Latency: read data registered one edge after rdAddr; write visible next edge.
// Backpressure: none, reads and writes accepted every cycle.
// Same-address read and write on one edge returns the old word.
module pe_lane_store #(
  parameter int A  = 7,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          wrEn,
  input  logic [A-1:0]  wrAddr,
  input  logic [DW-1:0] wrData,
  input  logic [A-1:0]  rdAddr,
  output logic [DW-1:0] rdData
);

  logic [DW-1:0] mem [2**A];

  // Contents survive reset on purpose; only the read register is cleared.
  always_ff @(posedge CLK) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) rdData <= '0;
    else       rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/pe_mac_lanes.sv
// Processing element: self-sequenced LANES-wide dot product over kernel/neuron
// stores, plus upstream partial sum. Latency len+3 edges (1 edge for len=0).
// Backpressure: result held in HOLD until outValid&&outReady; start ignored while busy.
// Ports: CLK, RSTn (async active-low), io (pe_mac_lanes_if.slave).
// Build option: define PE_SAT_EN for saturating accumulate and final add.
module pe_mac_lanes
  import pe_pkg::*;
#(
  parameter int W     = 16,
  parameter int A     = 7,
  parameter int LANES = 2,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic           CLK,
  input  logic           RSTn,
  pe_mac_lanes_if.slave  io
);

  localparam int DW   = LANES * W;
  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [A-1:0]    ONE_A   = 1;
  localparam logic [DC_W-1:0] ONE_DC  = 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_CYCLES);

  peState_t state, stateNext;

  logic [A-1:0]      baseKr, nPtr, strideR, lenR, stepCnt;
  logic [A-1:0]      kAddr;
  logic [DC_W-1:0]   drainCnt;
  logic [DW-1:0]     kRd, nRd;
  logic              rdVld, prodVld;
  logic signed [W-1:0]     kLane [LANES];
  logic signed [W-1:0]     nLane [LANES];
  logic signed [2*W-1:0]   prod  [LANES];
  logic signed [ACC_W-1:0] acc, stepSum, accStep, resultSum;
  logic [ACC_W-1:0]        adderOutR;

  assign kAddr = baseKr + stepCnt;

  pe_lane_store #(.A(A), .DW(DW)) kStore (
    .CLK(CLK), .RSTn(RSTn),
    .wrEn(io.kernelWrite), .wrAddr(io.kernelWrAddr), .wrData(io.kernelIn),
    .rdAddr(kAddr), .rdData(kRd)
  );

  pe_lane_store #(.A(A), .DW(DW)) nStore (
    .CLK(CLK), .RSTn(RSTn),
    .wrEn(io.neuronWrite), .wrAddr(io.neuronWrAddr), .wrData(io.neuronIn),
    .rdAddr(nPtr), .rdData(nRd)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= stateNext;
  end

  // len=0 goes through DRAIN with its counter preloaded to the last value,
  // so adderIn is captured one edge after start like every other result.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (io.start) stateNext = (io.len == '0) ? DRAIN : RUN;
      RUN:     if (stepCnt == lenR - ONE_A) stateNext = DRAIN;
      DRAIN:   if (drainCnt == DC_LAST) stateNext = HOLD;
      HOLD:    if (io.outReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    io.busy     = (state != IDLE);
    io.outValid = (state == HOLD);
  end

  assign io.adderOut = adderOutR;

  // ---------------- lane datapath ----------------
  for (genvar i = 0; i < LANES; i++) begin : gLane
    assign kLane[i] = kRd[i*W +: W];
    assign nLane[i] = nRd[i*W +: W];
  end

  always_comb begin
    stepSum = '0;
    for (int i = 0; i < LANES; i++) stepSum = stepSum + ACC_W'(prod[i]);
  end

`ifdef PE_SAT_EN
  assign accStep   = ACC_W'(satAdd(64'(acc), 64'(stepSum), ACC_W));
  assign resultSum = ACC_W'(satAdd(64'(acc), 64'(signed'(io.adderIn)), ACC_W));
`else
  assign accStep   = acc + stepSum;
  assign resultSum = acc + signed'(io.adderIn);
`endif

  // Read data valid tracks RUN cycles one edge late; products one more edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rdVld   <= 1'b0;
      prodVld <= 1'b0;
      for (int i = 0; i < LANES; i++) prod[i] <= '0;
    end else begin
      rdVld   <= (state == RUN);
      prodVld <= rdVld;
      for (int i = 0; i < LANES; i++) prod[i] <= (2*W)'(kLane[i]) * (2*W)'(nLane[i]);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      baseKr    <= '0;
      nPtr      <= '0;
      strideR   <= '0;
      lenR      <= '0;
      stepCnt   <= '0;
      drainCnt  <= '0;
      acc       <= '0;
      adderOutR <= '0;
    end else begin
      if (state == IDLE && io.start) acc <= '0;
      else if (prodVld)              acc <= accStep;

      case (state)
        IDLE: if (io.start) begin
          baseKr   <= io.baseK;
          nPtr     <= io.baseN;
          strideR  <= io.strideN;
          lenR     <= io.len;
          stepCnt  <= '0;
          drainCnt <= (io.len == '0) ? DC_LAST : '0;
        end
        RUN: begin
          stepCnt <= stepCnt + ONE_A;
          nPtr    <= nPtr + strideR;
        end
        DRAIN: begin
          drainCnt <= drainCnt + ONE_DC;
          if (drainCnt == DC_LAST) adderOutR <= resultSum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_lanes.sv
// Bench for pe_mac_lanes: directed cases plus randomized runs scored against
// an arithmetic dot-product model over shadow copies of both stores.
module tb_pe_mac_lanes;

  localparam int W = 16, A = 7, LANES = 2, ACC_W = 32;
  localparam int DEPTH = 2**A;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  pe_mac_lanes_if #(.W(W), .A(A), .LANES(LANES), .ACC_W(ACC_W)) bus ();

  pe_mac_lanes #(.W(W), .A(A), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .CLK(clk), .RSTn(rstN), .io(bus)
  );

  int total = 0;
  int bad   = 0;
  int kMem [DEPTH][LANES];
  int nMem [DEPTH][LANES];

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint fixAcc(input longint v);
`ifdef PE_SAT_EN
    longint mx, mn;
    mx = (longint'(1) <<< (ACC_W - 1)) - 1;
    mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
`else
    return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
`endif
  endfunction

  function automatic longint modelRun(input int bk, input int bn, input int st,
                                      input int ln, input longint addIn);
    longint acc, s;
    int ka, na;
    acc = 0;
    for (int i = 0; i < ln; i++) begin
      ka = (bk + i) % DEPTH;
      na = (bn + i * st) % DEPTH;
      s  = 0;
      for (int l = 0; l < LANES; l++) s += longint'(kMem[ka][l]) * longint'(nMem[na][l]);
      acc = fixAcc(acc + s);
    end
    return fixAcc(acc + addIn);
  endfunction

  task automatic writeRow(input int addr, input bit doK, input int k0, input int k1,
                          input bit doN, input int n0, input int n1);
    bus.kernelWrite  = doK;
    bus.kernelWrAddr = A'(addr);
    bus.kernelIn     = {16'(k1), 16'(k0)};
    bus.neuronWrite  = doN;
    bus.neuronWrAddr = A'(addr);
    bus.neuronIn     = {16'(n1), 16'(n0)};
    if (doK) begin kMem[addr][0] = k0; kMem[addr][1] = k1; end
    if (doN) begin nMem[addr][0] = n0; nMem[addr][1] = n1; end
    @(posedge clk); #1;
    bus.kernelWrite = 1'b0;
    bus.neuronWrite = 1'b0;
  endtask

  task automatic doRun(input string tag, input int bk, input int bn, input int st,
                       input int ln, input longint addIn, input int holdCyc);
    longint expv;
    int n;
    expv = modelRun(bk, bn, st, ln, addIn);
    bus.baseK    = A'(bk);
    bus.baseN    = A'(bn);
    bus.strideN  = A'(st);
    bus.len      = A'(ln);
    bus.adderIn  = ACC_W'(addIn);
    bus.outReady = 1'b0;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, ".busy"}, longint'(bus.busy), 1);
    n = 0;
    while (!bus.outValid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, n, (ln == 0) ? 1 : ln + 3);
    chk({tag, ".res"}, longint'($signed(bus.adderOut)), expv);
    for (int h = 0; h < holdCyc; h++) begin
      bus.start   = (h == 1);
      bus.adderIn = ACC_W'($urandom());
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, ".holdV"}, longint'(bus.outValid), 1);
      chk({tag, ".holdD"}, longint'($signed(bus.adderOut)), expv);
    end
    bus.outReady = 1'b1;
    bus.start    = (holdCyc > 0);
    @(posedge clk); #1;
    bus.outReady = 1'b0;
    bus.start    = 1'b0;
    chk({tag, ".idleB"}, longint'(bus.busy), 0);
    chk({tag, ".idleV"}, longint'(bus.outValid), 0);
  endtask

  function automatic int rndElem();
    return int'($urandom_range(0, 65534)) - 32767;
  endfunction

  initial begin
    bus.kernelWrite = 0; bus.kernelWrAddr = '0; bus.kernelIn = '0;
    bus.neuronWrite = 0; bus.neuronWrAddr = '0; bus.neuronIn = '0;
    bus.start = 0; bus.baseK = '0; bus.baseN = '0; bus.strideN = '0;
    bus.len = '0; bus.adderIn = '0; bus.outReady = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", longint'(bus.busy), 0);
    chk("rst.valid", longint'(bus.outValid), 0);
    chk("rst.out", longint'($signed(bus.adderOut)), 0);
    rstN = 1'b1;

    for (int a = 0; a < DEPTH; a++)
      writeRow(a, 1, rndElem(), rndElem(), 1, rndElem(), rndElem());

    writeRow(0, 1, 1, 2, 1, 1, 2);
    writeRow(1, 1, 3, 4, 1, 3, 4);
    writeRow(2, 1, 5, 6, 1, 5, 6);
    writeRow(3, 1, 7, 8, 1, 7, 8);
    writeRow(126, 0, 0, 0, 1, 9, 10);

    doRun("basic", 0, 0, 1, 4, 10, 0);
    chk("basic.214", longint'($signed(bus.adderOut)), 214);
    doRun("wrapAddr", 0, 126, 2, 4, 10, 0);
    doRun("len0", 5, 5, 1, 0, -5, 0);
    doRun("hold", 0, 0, 1, 4, 10, 5);

    writeRow(10, 1, 32767, 32767, 1, 32767, 32767);
    writeRow(11, 1, 32767, 32767, 1, 32767, 32767);
    doRun("sat", 10, 10, 1, 2, 0, 0);

    // Abort a len=8 run two edges in; the result register was nonzero before.
    bus.baseK = A'(20); bus.baseN = A'(40); bus.strideN = A'(3);
    bus.len = A'(8); bus.adderIn = '0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    chk("abort.busy", longint'(bus.busy), 0);
    chk("abort.valid", longint'(bus.outValid), 0);
    chk("abort.out", longint'($signed(bus.adderOut)), 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    doRun("afterAbort", 20, 40, 3, 8, 7, 0);

    for (int r = 0; r < 12; r++)
      doRun("rnd", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
            int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)),
            longint'($signed($urandom())), (r % 4 == 0) ? 2 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
